// File: rtl/four_bit_counter.sv
// Up/down tally counter: one registered WIDTH-bit value, stepped by one per
// clock while an enable is high, wrapping modulo 2**WIDTH in both directions.
module four_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count,
    input  logic             deCount,
    output logic [WIDTH-1:0] out
);

    // count is tested before deCount so an undriven deCount cannot leak into
    // the result whenever reset or count is asserted.
    always_ff @(posedge clk) begin
        if (reset)
            out <= '0;
        else if (count)
            out <= out + WIDTH'(1);
        else if (deCount)
            out <= out - WIDTH'(1);
    end

endmodule

// File: tb/tb_four_bit_counter.sv
// Directed plus randomized checks of four_bit_counter against a modulo-16
// arithmetic reference model.
module tb_four_bit_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       count;
    logic       deCount;
    logic [3:0] out;

    int checks = 0;
    int errors = 0;
    int model  = 0;

    four_bit_counter #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .count   (count),
        .deCount (deCount),
        .out     (out)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic c, input logic d,
                        input int exp, input string tag);
        logic [3:0] want;
        want = 4'(exp);
        @(negedge clk);
        reset   = r;
        count   = c;
        deCount = d;
        @(posedge clk);
        #1;
        checks++;
        assert (out === want) else begin
            errors++;
            $error("FAIL %s: out=%0d expected %0d", tag, out, want);
        end
        model = exp % 16;
    endtask

    // Reference rule: reset beats count beats deCount, arithmetic mod 16.
    function automatic int next_val(input int cur, input logic r,
                                    input logic c, input logic d);
        if (r)             return 0;
        else if (c)        return (cur + 1) % 16;
        else if (d === 1'b1) return (cur + 15) % 16;
        else               return cur;
    endfunction

    initial begin
        reset = 1'b1; count = 1'b0; deCount = 1'b0;

        step(1, 0, 0, 0, "reset");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, "reset_holds");

        for (int i = 1; i <= 2; i++) step(0, 1, 0, i, "count_up");
        step(0, 0, 0, 2, "hold");
        for (int i = 3; i <= 6; i++) step(0, 1, 0, i, "count_up2");

        step(1, 0, 0, 0, "reset_inc_wrap");
        for (int i = 1; i <= 15; i++) step(0, 1, 0, i, "inc_to_max");
        step(0, 1, 0, 0, "inc_wrap");

        for (int i = 1; i <= 2; i++) step(0, 1, 0, i, "to_two");
        for (int i = 1; i <= 11; i++) step(0, 0, 1, (2 - i + 16) % 16, "dec_wrap");

        step(1, 0, 0, 0, "reset_simul");
        for (int i = 1; i <= 5; i++) step(0, 1, 0, i, "to_five");
        step(0, 1, 1, 6, "both_enables");
        step(0, 1, 1'bx, 7, "decount_x");
        checks++;
        assert (!$isunknown(out)) else begin
            errors++;
            $error("FAIL decount_x_known: out=%b expected no X", out);
        end

        for (int i = 8; i <= 9; i++) step(0, 1, 0, i, "to_nine");
        step(1, 1, 0, 0, "reset_mid_count");
        step(0, 1, 0, 1, "resume");

        for (int i = 0; i < 300; i++) begin
            logic r, c, d;
            r = ($urandom_range(0, 19) == 0);
            c = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
            step(r, c, d, next_val(model, r, c, d), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
